// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the burst master.
// Transfer types, response codes and master FSM states.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HR_OKAY  = 1'b0,
    HR_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } mstate_e;

endpackage

// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst master: pipelined address/data phases,
// read data return and done/err completion pulses.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_INC = 1,
  parameter int LEN_W    = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  output logic              hsel,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  mstate_e state, state_n;

  logic              wr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_hold;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              dph;
  logic              hold;
  logic              rd_valid_q;
  logic              done_q;
  logic              err_q;

  logic active;
  logic accept;
  logic rd_hit;
  logic fin;
  logic fin_err;

  always_ff @(posedge hclk) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    hsel      = 1'b0;
    hwrite    = 1'b0;
    htrans    = HT_IDLE;
    active    = 1'b0;
    accept    = 1'b0;
    rd_hit    = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = S_ADDR;
      end
      S_ADDR: begin
        hsel   = 1'b1;
        hwrite = wr_q;
        // a stalled beat stays issued even if wr_valid drops
        active = hold || !wr_q || wr_valid;
        if (active)
          htrans = (beat == '0) ? HT_NONSEQ : HT_SEQ;
        else if (beat != '0)
          htrans = HT_BUSY;
        if (dph && hresp) begin
          if (hready) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_ERR;
          end
        end else begin
          accept = active && hready;
          rd_hit = dph && hready && !wr_q;
          if (accept && beat == len_q)
            state_n = S_LAST;
        end
      end
      S_LAST: begin
        hsel   = 1'b1;
        hwrite = wr_q;
        if (hresp) begin
          if (hready) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_ERR;
          end
        end else if (hready) begin
          fin     = 1'b1;
          rd_hit  = !wr_q;
          state_n = S_IDLE;
        end
      end
      S_ERR: begin
        hsel   = 1'b1;
        hwrite = wr_q;
        if (hready) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_q       <= 1'b0;
      len_q      <= '0;
      beat       <= '0;
      addr_q     <= '0;
      wd_hold    <= '0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      dph        <= 1'b0;
      hold       <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= fin;
      err_q      <= fin_err;
      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= hrdata;
      hold <= (state_n == S_ADDR) && active && !hready;
      if (active && !hold) wd_hold <= wr_data;
      if (hready) dph <= accept;
      if (state == S_IDLE && cmd_valid) begin
        wr_q   <= cmd_write;
        len_q  <= cmd_len;
        addr_q <= cmd_addr;
        beat   <= '0;
        dph    <= 1'b0;
      end
      if (accept) begin
        beat   <= beat + 1'b1;
        addr_q <= addr_q + ADDR_W'(ADDR_INC);
        if (wr_q) hwdata_q <= hold ? wd_hold : wr_data;
      end
    end
  end

  assign wr_ready = accept && wr_q;
  assign haddr    = addr_q;
  assign hwdata   = hwdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed, table-driven bench for ahb_burst_master.
// Each row: per-cycle inputs and the outputs expected that cycle.
module tb_ahb_burst_master;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, done, err;
  logic [31:0] rd_data;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hsel, hready, hresp;
  logic [1:0]  htrans;

  int passed = 0;
  int total  = 0;

  always #5 hclk = ~hclk;

  ahb_burst_master dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hwdata(hwdata), .hsel(hsel),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic        rst, cv, cw;
    logic [31:0] ca;
    logic [3:0]  cl;
    logic        wv;
    logic [31:0] wd;
    logic        hr, hp;
    logic [31:0] hd;
    logic        rdy;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic        sel, wrdy, wchk;
    logic [31:0] hwd;
    logic        rv;
    logic [31:0] rd;
    logic        dn, er;
  } vec_t;

  vec_t q[$];

  function automatic vec_t t(
    input logic rst, cv, cw, input logic [31:0] ca,
    input logic [3:0] cl, input logic wv, input logic [31:0] wd,
    input logic hr, hp, input logic [31:0] hd,
    input logic rdy, input logic [1:0] tr, input logic [31:0] ad,
    input logic sel, wrdy, wchk, input logic [31:0] hwd,
    input logic rv, input logic [31:0] rd, input logic dn, er);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl;
    v.wv = wv; v.wd = wd; v.hr = hr; v.hp = hp; v.hd = hd;
    v.rdy = rdy; v.tr = tr; v.ad = ad; v.sel = sel;
    v.wrdy = wrdy; v.wchk = wchk; v.hwd = hwd;
    v.rv = rv; v.rd = rd; v.dn = dn; v.er = er;
    return v;
  endfunction

  initial begin
    hreset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_len = 0; wr_valid = 0; wr_data = 0;
    hready = 1; hresp = 0; hrdata = 0;

    // single write, addr 5
    q.push_back(t(0,1,1,5,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'hA5A5,1,0,0, 0,2,5,1,1, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0, 1,'hA5A5,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,1,0));
    // single read, addr 2
    q.push_back(t(0,1,0,2,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,2,2,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,3, 0,0,0,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,1,3,1,0));
    // 4-beat write, addr 8, wr_valid low 2 cycles
    q.push_back(t(0,1,1,8,3, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h10,1,0,0, 0,2,8,1,1, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h11,1,0,0, 0,3,9,1,1, 1,'h10,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,1,10,1,0, 1,'h11,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,1,10,1,0, 1,'h11,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h12,1,0,0, 0,3,10,1,1, 1,'h11,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h13,1,0,0, 0,3,11,1,1, 1,'h12,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0, 1,'h13,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,1,0));
    // 4-beat read, wait state on beat 1, stray cmd_valid mid-burst
    q.push_back(t(0,1,0,'h20,3, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,2,'h20,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,1,1,'h99,0, 0,0,1,0,'h100, 0,3,'h21,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,0,0,0, 0,3,'h22,1,0, 0,0,1,'h100,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,'h101, 0,3,'h22,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,'h102, 0,3,'h23,1,0, 0,0,1,'h101,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,'h103, 0,0,0,1,0, 0,0,1,'h102,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,1,'h103,1,0));
    // write addr 1, two-cycle ERROR on first data phase
    q.push_back(t(0,1,1,1,3, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h55,1,0,0, 0,2,1,1,1, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h66,0,1,0, 0,3,2,1,0, 1,'h55,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h66,1,1,0, 0,0,0,1,0, 1,'h55,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'h66,1,0,0, 1,0,0,0,0, 0,0,0,0,1,1));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    // read, ERROR with hready=1 on first data phase
    q.push_back(t(0,1,0,'h10,2, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,2,'h10,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,1,'hDEAD, 0,3,'h11,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,1,1));
    // write, wr_valid drops while beat 1 is stalled
    q.push_back(t(0,1,1,'h50,1, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'hA1,1,0,0, 0,2,'h50,1,1, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'hA2,0,0,0, 0,3,'h51,1,0, 1,'hA1,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,'hFF,1,0,0, 0,3,'h51,1,1, 1,'hA1,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0, 1,'hA2,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,1,0));
    // reset mid 8-beat read, then a fresh single write
    q.push_back(t(0,1,0,'h40,7, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,2,'h40,1,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,7, 0,3,'h41,1,0, 0,0,0,0,0,0));
    q.push_back(t(1,0,0,0,0, 0,0,1,0,0, 0,3,'h42,1,0, 0,0,1,7,0,0));
    q.push_back(t(0,1,1,'h30,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 1,'hBEEF,1,0,0, 0,2,'h30,1,1, 0,0,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0, 1,'hBEEF,0,0,0,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,1,0));
    q.push_back(t(0,0,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 0,0,0,0,0,0));

    // reset state
    repeat (2) @(posedge hclk);
    #1;
    total++;
    if (cmd_ready === 1'b1 && htrans === 2'b00 && hsel === 1'b0 &&
        hwrite === 1'b0 && done === 1'b0 && err === 1'b0 &&
        rd_valid === 1'b0 && wr_ready === 1'b0 &&
        haddr === 32'h0 && hwdata === 32'h0)
      passed++;
    else
      $display("FAIL reset: rdy=%b tr=%b sel=%b wr=%b dn=%b er=%b rv=%b a=%h wd=%h, required rdy=1 others 0",
               cmd_ready, htrans, hsel, hwrite, done, err, rd_valid,
               haddr, hwdata);

    for (int i = 0; i < q.size(); i++) begin
      vec_t v;
      logic ok;
      v = q[i];
      @(negedge hclk);
      hreset = v.rst; cmd_valid = v.cv; cmd_write = v.cw;
      cmd_addr = v.ca; cmd_len = v.cl;
      wr_valid = v.wv; wr_data = v.wd;
      hready = v.hr; hresp = v.hp; hrdata = v.hd;
      #1;
      ok = (cmd_ready === v.rdy) && (htrans === v.tr) &&
           (hsel === v.sel) && (wr_ready === v.wrdy) &&
           (rd_valid === v.rv) && (done === v.dn) && (err === v.er) &&
           (v.tr == 2'b00 || haddr === v.ad) &&
           (!v.wchk || hwdata === v.hwd) &&
           (!v.rv || rd_data === v.rd);
      total++;
      if (ok) passed++;
      else
        $display("FAIL row %0d: got rdy=%b tr=%0d a=%h sel=%b wrdy=%b wd=%h rv=%b rd=%h dn=%b er=%b; required rdy=%b tr=%0d a=%h sel=%b wrdy=%b wd=%h rv=%b rd=%h dn=%b er=%b",
                 i, cmd_ready, htrans, haddr, hsel, wr_ready, hwdata,
                 rd_valid, rd_data, done, err,
                 v.rdy, v.tr, v.ad, v.sel, v.wrdy, v.hwd,
                 v.rv, v.rd, v.dn, v.er);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
